// File: rtl/taus_urng_pair.sv
// Paired Taus88 uniform random source: two three-component Tausworthe generators
// with seed legality correction, a warm-up discard phase and a valid/ready output stage.

module taus88_gen (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed_s0,
  input  logic [31:0] seed_s1,
  input  logic [31:0] seed_s2,
  output logic [31:0] next_word
);

  logic [31:0] s0;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [31:0] n0;
  logic [31:0] n1;
  logic [31:0] n2;

  always_comb begin
    n0 = ((s0 & 32'hFFFF_FFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19);
    n1 = ((s1 & 32'hFFFF_FFF8) << 4)  ^ (((s1 << 2)  ^ s1) >> 25);
    n2 = ((s2 & 32'hFFFF_FFF0) << 17) ^ (((s2 << 3)  ^ s2) >> 11);
    next_word = n0 ^ n1 ^ n2;
  end

  // Seeds below the per-component minimum would lock that component at zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else if (load) begin
      s0 <= (seed_s0 < 32'd2)  ? 32'd2  : seed_s0;
      s1 <= (seed_s1 < 32'd8)  ? 32'd8  : seed_s1;
      s2 <= (seed_s2 < 32'd16) ? 32'd16 : seed_s2;
    end else if (advance) begin
      s0 <= n0;
      s1 <= n1;
      s2 <= n2;
    end
  end

endmodule

// state    | meaning
// ---------+------------------------------------------------------------
// UNSEEDED | after reset; generators idle, no output
// WARMUP   | both generators step, results discarded, busy=1
// RUN      | output register refills whenever empty or being accepted
module taus_urng_pair #(
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 seed_load,
  input  logic [31:0]          seed1,
  input  logic [31:0]          seed2,
  input  logic [31:0]          seed3,
  input  logic [31:0]          seed4,
  input  logic [31:0]          seed5,
  input  logic [31:0]          seed6,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [31:0]          urng_out1,
  output logic [31:0]          urng_out2,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] sample_count
);

  localparam int unsigned WW = (WARMUP_CYCLES < 2) ? 1 : $clog2(WARMUP_CYCLES);
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    UNSEEDED,
    WARMUP,
    RUN
  } state_t;

  state_t        state;
  logic [WW-1:0] warm_cnt;
  logic          run_step;
  logic          advance;
  logic [31:0]   word_a;
  logic [31:0]   word_b;

  always_comb begin
    run_step = (state == RUN) && (!out_valid || out_ready);
    advance  = run_step || (state == WARMUP);
  end

  taus88_gen u_gen_a (
    .clock     (clock),
    .reset     (reset),
    .load      (seed_load),
    .advance   (advance),
    .seed_s0   (seed1),
    .seed_s1   (seed2),
    .seed_s2   (seed3),
    .next_word (word_a)
  );

  taus88_gen u_gen_b (
    .clock     (clock),
    .reset     (reset),
    .load      (seed_load),
    .advance   (advance),
    .seed_s0   (seed4),
    .seed_s1   (seed5),
    .seed_s2   (seed6),
    .next_word (word_b)
  );

  // A reseed drops any pending pair and wins over a same-cycle accept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= UNSEEDED;
      warm_cnt     <= '0;
      out_valid    <= 1'b0;
      urng_out1    <= '0;
      urng_out2    <= '0;
      busy         <= 1'b0;
      sample_count <= '0;
    end else if (seed_load) begin
      out_valid    <= 1'b0;
      sample_count <= '0;
      warm_cnt     <= '0;
      if (WARMUP_CYCLES == 0) begin
        state <= RUN;
        busy  <= 1'b0;
      end else begin
        state <= WARMUP;
        busy  <= 1'b1;
      end
    end else begin
      case (state)
        UNSEEDED: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        WARMUP: begin
          if (warm_cnt == WARM_LAST) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            warm_cnt <= warm_cnt + WW'(1);
          end
        end
        RUN: begin
          if (out_valid && out_ready)
            sample_count <= sample_count + CNT_WIDTH'(1);
          if (run_step) begin
            urng_out1 <= word_a;
            urng_out2 <= word_b;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= UNSEEDED;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
